// File: rtl/tmem_xbar_rr_pkg.sv
// Shared helpers for the TMEM crossbar: ceiling-log2 used to size bank-select and core-index fields.
package tmem_xbar_rr_pkg;

    // Number of bits needed to encode n distinct values (n >= 2).
    function automatic int clog2_f(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tmem_xbar_rr_arbiter.sv
// Round-robin arbiter for one TMEM bank: picks the first requester at or after the pointer,
// then moves the pointer to one past the winner. Pointer holds when nobody requests.
module rr_arbiter
    import tmem_xbar_rr_pkg::*;
#(
    parameter  int N  = 16,
    localparam int IW = clog2_f(N)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [N-1:0]  req_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          vld_o
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] idx;
    logic          found;

    // Scan requesters starting at the pointer, wrapping at N.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && req_i[(int'(ptr_q) + k) % N]) begin
                found = 1'b1;
                idx   = IW'((int'(ptr_q) + k) % N);
            end
        end
    end

    // One-hot grant, index and next pointer from the scan result.
    always_comb begin
        gnt_o = '0;
        if (found) begin
            gnt_o[idx] = 1'b1;
        end
        idx_o = idx;
        vld_o = found;
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/tmem_xbar_rr.sv
// Core-to-TMEM read crossbar: per-bank round-robin arbitration, registered grant/address stage,
// one-stage winner tag alongside the bank read, registered return routing and conflict counters.
// Bank data is sampled in the cycle BANK_RE_O is high (the RAM's synchronous stage is the
// registered address), so request-to-DVAL latency is two cycles.
module tmem_xbar_rr
    import tmem_xbar_rr_pkg::*;
#(
    parameter int NCORES = 16,
    parameter int NBANKS = 4,
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int CW     = 16
) (
    input  logic                                     CLK_I,
    input  logic                                     RST_I,
    input  logic [NCORES-1:0]                        REQ_I,
    input  logic [NCORES*AW-1:0]                     ADR_I,
    output logic [NCORES-1:0]                        GNT_O,
    output logic [NCORES*DW-1:0]                     DAT_O,
    output logic [NCORES-1:0]                        DVAL_O,
    output logic [NBANKS-1:0]                        BANK_RE_O,
    output logic [NBANKS*(AW-clog2_f(NBANKS))-1:0]   BANK_ADR_O,
    input  logic [NBANKS*DW-1:0]                     BANK_DAT_I,
    input  logic                                     CLR_I,
    output logic [NBANKS*CW-1:0]                     CONFL_O
);

    localparam int BB = clog2_f(NBANKS);
    localparam int IW = clog2_f(NCORES);
    localparam int PW = AW - BB;

    logic [NBANKS-1:0][NCORES-1:0] bank_req;
    logic [NBANKS-1:0][NCORES-1:0] arb_gnt;
    logic [NBANKS-1:0][IW-1:0]     arb_idx;
    logic [NBANKS-1:0]             arb_vld;
    logic [NBANKS-1:0][PW-1:0]     win_adr;
    logic [NBANKS-1:0]             conflict;
    logic [NCORES-1:0]             gnt_d;

    logic [NCORES-1:0]             gnt_q;
    logic [NBANKS-1:0]             re_q;
    logic [NBANKS-1:0][PW-1:0]     adr_q;
    logic [NBANKS-1:0][IW-1:0]     tag_q;

    logic [NCORES-1:0]             dval_d, dval_q;
    logic [NCORES*DW-1:0]          dat_d, dat_q;
    logic [NBANKS-1:0][CW-1:0]     confl_q;

    // Demux requests by low-order bank select.
    always_comb begin
        for (int b = 0; b < NBANKS; b++) begin
            for (int i = 0; i < NCORES; i++) begin
                bank_req[b][i] = REQ_I[i] && (ADR_I[i*AW +: BB] == BB'(b));
            end
        end
    end

    for (genvar gb = 0; gb < NBANKS; gb++) begin : g_bank
        rr_arbiter #(.N(NCORES)) u_arb (
            .clk_i  (CLK_I),
            .rst_ni (RST_I),
            .req_i  (bank_req[gb]),
            .gnt_o  (arb_gnt[gb]),
            .idx_o  (arb_idx[gb]),
            .vld_o  (arb_vld[gb])
        );
    end

    // Winner physical address, grant merge and multi-requester detection per bank.
    always_comb begin
        gnt_d = '0;
        for (int b = 0; b < NBANKS; b++) begin
            win_adr[b]  = ADR_I[int'(arb_idx[b])*AW + BB +: PW];
            conflict[b] = |(bank_req[b] & (bank_req[b] - NCORES'(1)));
            gnt_d       = gnt_d | arb_gnt[b];
        end
    end

    // Grant/address stage; winner tag travels with the bank read. Address holds when idle.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            gnt_q <= '0;
            re_q  <= '0;
            adr_q <= '0;
            tag_q <= '0;
        end else begin
            gnt_q <= gnt_d;
            re_q  <= arb_vld;
            tag_q <= arb_idx;
            for (int b = 0; b < NBANKS; b++) begin
                if (arb_vld[b]) begin
                    adr_q[b] <= win_adr[b];
                end
            end
        end
    end

    // Route bank data back to the tagged core; a core owns at most one bank read per cycle.
    always_comb begin
        dval_d = '0;
        dat_d  = dat_q;
        for (int b = 0; b < NBANKS; b++) begin
            if (re_q[b]) begin
                dval_d[tag_q[b]]                   = 1'b1;
                dat_d[int'(tag_q[b])*DW +: DW]     = BANK_DAT_I[b*DW +: DW];
            end
        end
    end

    // Return stage registers.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            dval_q <= '0;
            dat_q  <= '0;
        end else begin
            dval_q <= dval_d;
            dat_q  <= dat_d;
        end
    end

    // Saturating conflict counters; clear has priority over increment.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            confl_q <= '0;
        end else if (CLR_I) begin
            confl_q <= '0;
        end else begin
            for (int b = 0; b < NBANKS; b++) begin
                if (conflict[b] && !(&confl_q[b])) begin
                    confl_q[b] <= confl_q[b] + CW'(1);
                end
            end
        end
    end

    assign GNT_O      = gnt_q;
    assign BANK_RE_O  = re_q;
    assign BANK_ADR_O = adr_q;
    assign DVAL_O     = dval_q;
    assign DAT_O      = dat_q;
    assign CONFL_O    = confl_q;

endmodule

// File: tb/tb_tmem_xbar_rr.sv
// Directed bench for tmem_xbar_rr (16 cores, 4 banks). Bank RAM model returns addr ^ 0xC0DE0000.
module tb_tmem_xbar_rr;

    logic          clk;
    logic          rst_n;
    logic [15:0]   req;
    logic [511:0]  adr;
    logic [15:0]   gnt;
    logic [511:0]  dat;
    logic [15:0]   dval;
    logic [3:0]    bank_re;
    logic [119:0]  bank_adr;
    logic [127:0]  bank_dat;
    logic          clr;
    logic [63:0]   confl;

    int checks;
    int failures;

    tmem_xbar_rr dut (
        .CLK_I      (clk),
        .RST_I      (rst_n),
        .REQ_I      (req),
        .ADR_I      (adr),
        .GNT_O      (gnt),
        .DAT_O      (dat),
        .DVAL_O     (dval),
        .BANK_RE_O  (bank_re),
        .BANK_ADR_O (bank_adr),
        .BANK_DAT_I (bank_dat),
        .CLR_I      (clr),
        .CONFL_O    (confl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Bank RAM model: data for the address currently registered on each bank.
    always_comb begin
        for (int b = 0; b < 4; b++) begin
            bank_dat[b*32 +: 32] = mem_f({bank_adr[b*30 +: 30], 2'(b)});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int core, input logic [31:0] a);
        adr[core*32 +: 32] = a;
        req[core]          = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        adr   = '0;
        clr   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        req   = '0;
        adr   = '0;
        clr   = 1'b0;
        rst_n = 1'b0;
        #3;
        checks++; if (gnt !== 16'h0) begin failures++; $display("FAIL reset_gnt got=%h exp=0", gnt); end
        checks++; if (dval !== 16'h0) begin failures++; $display("FAIL reset_dval got=%h exp=0", dval); end
        checks++; if (dat !== 512'h0) begin failures++; $display("FAIL reset_dat got nonzero exp=0"); end
        checks++; if (bank_re !== 4'h0) begin failures++; $display("FAIL reset_bank_re got=%h exp=0", bank_re); end
        checks++; if (bank_adr !== 120'h0) begin failures++; $display("FAIL reset_bank_adr got=%h exp=0", bank_adr); end
        checks++; if (confl !== 64'h0) begin failures++; $display("FAIL reset_confl got=%h exp=0", confl); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        set_req(0, 32'h9);
        tick();
        req = '0;
        checks++; if (gnt !== 16'h0001) begin failures++; $display("FAIL single_gnt got=%h exp=0001", gnt); end
        checks++; if (bank_re !== 4'b0010) begin failures++; $display("FAIL single_bank_re got=%b exp=0010", bank_re); end
        checks++; if (bank_adr[30 +: 30] !== 30'h2) begin failures++; $display("FAIL single_bank_adr got=%h exp=2", bank_adr[30 +: 30]); end
        checks++; if (dval !== 16'h0) begin failures++; $display("FAIL single_early_dval got=%h exp=0", dval); end
        tick();
        checks++; if (dval !== 16'h0001) begin failures++; $display("FAIL single_dval got=%h exp=0001", dval); end
        checks++; if (dat[31:0] !== mem_f(32'h9)) begin failures++; $display("FAIL single_dat got=%h exp=%h", dat[31:0], mem_f(32'h9)); end
        checks++; if (gnt !== 16'h0) begin failures++; $display("FAIL single_gnt_after got=%h exp=0", gnt); end
        tick();
        checks++; if (dval !== 16'h0) begin failures++; $display("FAIL single_dval_pulse got=%h exp=0", dval); end
        checks++; if (dat[31:0] !== mem_f(32'h9)) begin failures++; $display("FAIL single_dat_hold got=%h exp=%h", dat[31:0], mem_f(32'h9)); end
        checks++; if (bank_adr[30 +: 30] !== 30'h2) begin failures++; $display("FAIL single_adr_hold got=%h exp=2", bank_adr[30 +: 30]); end
    endtask

    task automatic test_fairness();
        logic [15:0] exp_g;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_req(i, 32'(2 + 4 * i));
        end
        for (int k = 0; k < 16; k++) begin
            tick();
            if (k == 15) req = '0;
            exp_g = 16'(1) << k;
            checks++; if (gnt !== exp_g) begin failures++; $display("FAIL rr_gnt step=%0d got=%h exp=%h", k, gnt, exp_g); end
            checks++; if (bank_adr[60 +: 30] !== 30'(k)) begin failures++; $display("FAIL rr_adr step=%0d got=%h exp=%h", k, bank_adr[60 +: 30], k); end
        end
        checks++; if (confl[32 +: 16] !== 16'd16) begin failures++; $display("FAIL rr_confl got=%0d exp=16", confl[32 +: 16]); end
        tick();
        checks++; if (confl[32 +: 16] !== 16'd16) begin failures++; $display("FAIL rr_confl_stop got=%0d exp=16", confl[32 +: 16]); end
        checks++; if ({confl[48 +: 16], confl[0 +: 32]} !== 48'h0) begin failures++; $display("FAIL rr_confl_other got=%h exp=0", confl); end
        checks++; if (gnt !== 16'h0) begin failures++; $display("FAIL rr_gnt_idle got=%h exp=0", gnt); end
    endtask

    task automatic test_parallel();
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 32'(i));
        tick();
        req = '0;
        checks++; if (gnt !== 16'h000F) begin failures++; $display("FAIL par_gnt got=%h exp=000f", gnt); end
        checks++; if (bank_re !== 4'hF) begin failures++; $display("FAIL par_bank_re got=%h exp=f", bank_re); end
        checks++; if (bank_adr !== 120'h0) begin failures++; $display("FAIL par_bank_adr got=%h exp=0", bank_adr); end
        tick();
        checks++; if (dval !== 16'h000F) begin failures++; $display("FAIL par_dval got=%h exp=000f", dval); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (dat[i*32 +: 32] !== mem_f(32'(i))) begin failures++; $display("FAIL par_dat core=%0d got=%h exp=%h", i, dat[i*32 +: 32], mem_f(32'(i))); end
        end
    endtask

    task automatic test_back_to_back();
        int k;
        do_reset();
        k = 0;
        set_req(5, 32'h0);
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++; if (gnt[5] !== (c < 8)) begin failures++; $display("FAIL b2b_gnt cyc=%0d got=%b exp=%b", c, gnt[5], (c < 8)); end
            checks++; if (dval[5] !== (c >= 1 && c < 9)) begin failures++; $display("FAIL b2b_dval cyc=%0d got=%b exp=%b", c, dval[5], (c >= 1 && c < 9)); end
            if (c >= 1 && c < 9) begin
                checks++; if (dat[5*32 +: 32] !== mem_f(32'(c - 1))) begin failures++; $display("FAIL b2b_dat cyc=%0d got=%h exp=%h", c, dat[5*32 +: 32], mem_f(32'(c - 1))); end
            end
            if (gnt[5] && k < 8) begin
                k = k + 1;
                if (k < 8) set_req(5, 32'(k));
                else req[5] = 1'b0;
            end
        end
        checks++; if (k !== 8) begin failures++; $display("FAIL b2b_count got=%0d exp=8", k); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) set_req(i, 32'(i));
        tick();
        checks++; if (bank_re !== 4'b0111) begin failures++; $display("FAIL rmid_inflight got=%b exp=0111", bank_re); end
        req   = '0;
        rst_n = 1'b0;
        #1;
        checks++; if (gnt !== 16'h0) begin failures++; $display("FAIL rmid_gnt got=%h exp=0", gnt); end
        checks++; if (bank_re !== 4'h0) begin failures++; $display("FAIL rmid_bank_re got=%h exp=0", bank_re); end
        checks++; if (bank_adr !== 120'h0) begin failures++; $display("FAIL rmid_bank_adr got=%h exp=0", bank_adr); end
        checks++; if (dval !== 16'h0) begin failures++; $display("FAIL rmid_dval got=%h exp=0", dval); end
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (dval !== 16'h0) begin failures++; $display("FAIL rmid_ghost_dval cyc=%0d got=%h exp=0", c, dval); end
        end
        set_req(0, 32'h0);
        set_req(1, 32'h4);
        tick();
        req = '0;
        checks++; if (gnt !== 16'h0001) begin failures++; $display("FAIL rmid_ptr_gnt got=%h exp=0001", gnt); end
    endtask

    task automatic test_conflict();
        do_reset();
        set_req(0, 32'h0);
        set_req(1, 32'h4);
        for (int c = 0; c < 65534; c++) tick();
        checks++; if (confl[15:0] !== 16'hFFFE) begin failures++; $display("FAIL sat_pre got=%h exp=fffe", confl[15:0]); end
        tick();
        checks++; if (confl[15:0] !== 16'hFFFF) begin failures++; $display("FAIL sat_max got=%h exp=ffff", confl[15:0]); end
        tick();
        tick();
        checks++; if (confl[15:0] !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got=%h exp=ffff", confl[15:0]); end
        checks++; if (confl[63:16] !== 48'h0) begin failures++; $display("FAIL sat_other got=%h exp=0", confl[63:16]); end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++; if (confl[15:0] !== 16'h0) begin failures++; $display("FAIL clr_wins got=%h exp=0", confl[15:0]); end
        tick();
        req = '0;
        checks++; if (confl[15:0] !== 16'h1) begin failures++; $display("FAIL clr_resume got=%h exp=1", confl[15:0]); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        req      = '0;
        adr      = '0;
        clr      = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_parallel();
        test_back_to_back();
        test_reset_mid();
        test_conflict();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
